interrupt_redirect_unit: RTL

Produces the interrupt redirect that the next-PC stage consumes as `interruptAddrIn`/`interruptAddrWE`. It watches external interrupt lines and requests a front-end flush. Once the flush is acknowledged, it issues a one-cycle PC write to a vectored handler address and saves the interrupted PC. It later issues a second PC write to return to that saved PC when `mret` retires.

---
 rtl/interrupt_redirect_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/interrupt_redirect_unit.sv
// -----------------------------------------------------------------------------
// interrupt_redirect_unit
//
// Watches level-sensitive interrupt lines. When an enabled line is pending
// while idle, it requests a front-end flush. After the flush is acknowledged it
// emits a one-cycle PC overwrite to the vectored handler address and saves the
// interrupted PC. When mret retires it emits a second one-cycle PC overwrite
// back to the saved PC.
//
// Every output comes straight from a register. The redirect target is computed
// one cycle early, on the edge that enters REDIRECT or RETURN, so that no input
// reaches an output combinationally.
// -----------------------------------------------------------------------------
module interrupt_redirect_unit #(
   parameter int PC_WIDTH    = 32,
   parameter int NUM_IRQ     = 4,
   parameter int CAUSE_WIDTH = 4
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic [PC_WIDTH-1:0]    i_pcOut,
   input  logic [NUM_IRQ-1:0]     i_irq,
   input  logic                   i_cfgWE,
   input  logic [NUM_IRQ-1:0]     i_cfgIrqEnable,
   input  logic                   i_cfgGlobalEnable,
   input  logic [PC_WIDTH-1:0]    i_vectorBase,
   output logic                   o_flushReq,
   input  logic                   i_flushAck,
   input  logic                   i_mretRetire,
   output logic [PC_WIDTH-1:0]    o_interruptAddrIn,
   output logic                   o_interruptAddrWE,
   output logic [PC_WIDTH-1:0]    o_epc,
   output logic [CAUSE_WIDTH-1:0] o_cause,
   output logic                   o_inHandler
);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_FLUSH    = 3'd1,
      S_REDIRECT = 3'd2,
      S_HANDLER  = 3'd3,
      S_RETURN   = 3'd4
   } state_t;

   // Lowest set index wins, so line 0 has the highest priority.
   function automatic logic [CAUSE_WIDTH-1:0] f_lowest_index(input logic [NUM_IRQ-1:0] v);
      logic [CAUSE_WIDTH-1:0] idx;
      idx = {CAUSE_WIDTH{1'b0}};
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = CAUSE_WIDTH'(i);
         end else begin
            idx = idx;
         end
      end
      return idx;
   endfunction

   state_t                 r_state;
   logic [NUM_IRQ-1:0]     r_irq_enable;
   logic                   r_global_enable;
   logic [PC_WIDTH-1:0]    r_epc;
   logic [CAUSE_WIDTH-1:0] r_cause;
   logic                   r_flush_req;
   logic [PC_WIDTH-1:0]    r_addr;
   logic                   r_addr_we;
   logic                   r_in_handler;

   logic [NUM_IRQ-1:0]     w_pend;
   logic [CAUSE_WIDTH-1:0] w_winner;
   logic [PC_WIDTH-1:0]    w_vec_base;
   logic [PC_WIDTH-1:0]    w_vec_target;
   logic                   w_enter_redirect;

   // Pending lines, winner selection and handler address (wraps on overflow).
   always_comb begin
      w_pend           = i_irq & r_irq_enable & {NUM_IRQ{r_global_enable}};
      w_winner         = f_lowest_index(w_pend);
      w_vec_base       = i_vectorBase & {{(PC_WIDTH-2){1'b1}}, 2'b00};
      w_vec_target     = w_vec_base + (PC_WIDTH'(r_cause) << 2);
      w_enter_redirect = (r_state == S_FLUSH) && i_flushAck;
   end

   // Enable registers: the hardware clear on entering REDIRECT, held through
   // REDIRECT, beats a software write; leaving RETURN re-arms the global enable.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_irq_enable    <= {NUM_IRQ{1'b0}};
         r_global_enable <= 1'b0;
      end else begin
         if (i_cfgWE) begin
            r_irq_enable <= i_cfgIrqEnable;
         end else begin
            r_irq_enable <= r_irq_enable;
         end

         if (w_enter_redirect || (r_state == S_REDIRECT)) begin
            r_global_enable <= 1'b0;
         end else if (r_state == S_RETURN) begin
            r_global_enable <= 1'b1;
         end else if (i_cfgWE) begin
            r_global_enable <= i_cfgGlobalEnable;
         end else begin
            r_global_enable <= r_global_enable;
         end
      end
   end

   // Redirect sequencer with registered outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= S_IDLE;
         r_epc        <= {PC_WIDTH{1'b0}};
         r_cause      <= {CAUSE_WIDTH{1'b0}};
         r_flush_req  <= 1'b0;
         r_addr       <= {PC_WIDTH{1'b0}};
         r_addr_we    <= 1'b0;
         r_in_handler <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_addr       <= {PC_WIDTH{1'b0}};
               r_addr_we    <= 1'b0;
               r_in_handler <= 1'b0;
               if (|w_pend) begin
                  r_cause     <= w_winner;
                  r_flush_req <= 1'b1;
                  r_state     <= S_FLUSH;
               end else begin
                  r_flush_req <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end

            S_FLUSH: begin
               // The cause stays frozen and the flush is never aborted by irq
               // dropping or by enable changes.
               if (i_flushAck) begin
                  r_flush_req  <= 1'b0;
                  r_addr_we    <= 1'b1;
                  r_addr       <= w_vec_target;
                  r_in_handler <= 1'b1;
                  r_state      <= S_REDIRECT;
               end else begin
                  r_flush_req <= 1'b1;
                  r_state     <= S_FLUSH;
               end
            end

            S_REDIRECT: begin
               r_epc       <= i_pcOut;
               r_flush_req <= 1'b0;
               r_addr_we   <= 1'b0;
               r_addr      <= {PC_WIDTH{1'b0}};
               r_state     <= S_HANDLER;
            end

            S_HANDLER: begin
               // No nesting: pending lines are only looked at in IDLE.
               if (i_mretRetire) begin
                  r_addr_we <= 1'b1;
                  r_addr    <= r_epc;
                  r_state   <= S_RETURN;
               end else begin
                  r_addr_we <= 1'b0;
                  r_addr    <= {PC_WIDTH{1'b0}};
                  r_state   <= S_HANDLER;
               end
            end

            S_RETURN: begin
               r_addr_we    <= 1'b0;
               r_addr       <= {PC_WIDTH{1'b0}};
               r_in_handler <= 1'b0;
               r_state      <= S_IDLE;
            end

            default: begin
               r_flush_req  <= 1'b0;
               r_addr_we    <= 1'b0;
               r_addr       <= {PC_WIDTH{1'b0}};
               r_in_handler <= 1'b0;
               r_state      <= S_IDLE;
            end
         endcase
      end
   end

   assign o_flushReq        = r_flush_req;
   assign o_interruptAddrIn = r_addr;
   assign o_interruptAddrWE = r_addr_we;
   assign o_epc             = r_epc;
   assign o_cause           = r_cause;
   assign o_inHandler       = r_in_handler;

endmodule
